// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
        logic        thumb;
    } fetch_entry_t;

    localparam logic [31:0] ARM_STEP   = 32'd4;
    localparam logic [31:0] THUMB_STEP = 32'd2;

    // Thumb entries carry the whole fetched word; pc[1] picks the halfword.
    function automatic logic [31:0] entry_instr(input fetch_entry_t e);
        if (!e.thumb) begin
            return e.word;
        end else if (e.pc[1]) begin
            return {16'h0000, e.word[31:16]};
        end else begin
            return {16'h0000, e.word[15:0]};
        end
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry prefetch FIFO of fetch entries
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_clear,
    input  fetch_entry_t               i_data,
    output fetch_entry_t               o_head,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    fetch_entry_t    r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic            w_push;
    logic            w_pop;

    assign w_push = i_push && (r_count != L_FULL);
    assign w_pop  = i_pop  && (r_count != '0);

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/arm_fetch_unit.sv
// rtl/arm_fetch_unit.sv - ARM7 fetch stage: fetch PC, bus read FSM, prefetch queue
module arm_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          DEPTH        = 2
) (
    input  logic        CLK,
    input  logic        reset_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        flush,
    input  logic [31:0] flush_addr,
    input  logic        flush_thumb,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_thumb,
    output logic        instr_valid,
    input  logic        instr_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_DEPTH    = (AW+1)'(DEPTH);
    localparam logic [AW:0] L_DEPTH_M1 = (AW+1)'(DEPTH - 1);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic         r_thumb;
    logic         w_thumb_nxt;
    logic [31:0]  r_disc_addr;
    logic [31:0]  w_step;
    logic [AW:0]  w_count;
    logic         w_push;
    logic         w_pop;
    logic         w_room_after;
    fetch_entry_t w_push_entry;
    fetch_entry_t w_head;

    assign w_step       = r_thumb ? THUMB_STEP : ARM_STEP;
    assign w_pop        = instr_valid && instr_ready && !flush;
    assign w_push       = (r_state == REQ) && mem_ack && !flush;
    // A same-cycle pop frees the slot the push is about to take.
    assign w_room_after = w_pop || (w_count < L_DEPTH_M1);
    assign w_push_entry = '{word: mem_rdata, pc: r_pc, thumb: r_thumb};

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_thumb_nxt = r_thumb;
        if (flush) begin
            w_pc_nxt    = flush_addr & ~32'h1;
            w_thumb_nxt = flush_thumb;
        end
        case (r_state)
            IDLE: begin
                if (flush || (w_count < L_DEPTH)) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (flush) begin
                    w_state_nxt = mem_ack ? REQ : DISCARD;
                end else if (mem_ack) begin
                    w_pc_nxt    = r_pc + w_step;
                    w_state_nxt = w_room_after ? REQ : IDLE;
                end
            end
            DISCARD: begin
                if (mem_ack) begin
                    w_state_nxt = REQ;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_pc        <= RESET_VECTOR;
            r_thumb     <= 1'b0;
            r_disc_addr <= RESET_VECTOR;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_thumb <= w_thumb_nxt;
            // The abandoned address must stay on the bus until its ack arrives.
            if ((r_state == REQ) && flush && !mem_ack) begin
                r_disc_addr <= mem_addr;
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .i_clk   (CLK),
        .i_rst_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (flush),
        .i_data  (w_push_entry),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign mem_req     = (r_state != IDLE);
    assign mem_addr    = (r_state == DISCARD) ? r_disc_addr : {r_pc[31:2], 2'b00};
    assign instr       = entry_instr(w_head);
    assign instr_pc    = w_head.pc;
    assign instr_thumb = w_head.thumb;
    assign instr_valid = (w_count != '0);

endmodule

// File: tb/tb_arm_fetch_unit.sv
// tb/tb_arm_fetch_unit.sv - self-checking bench for arm_fetch_unit
module tb_arm_fetch_unit;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        thumb;
    } exp_t;

    logic        CLK;
    logic        reset_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        flush;
    logic [31:0] flush_addr;
    logic        flush_thumb;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_thumb;
    logic        instr_valid;
    logic        instr_ready;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          ack_budget = 0;
    int          ack_delay  = 0;
    int          wait_cnt   = 0;
    logic        pend       = 1'b0;
    logic [31:0] pend_addr  = 32'h0;
    logic [31:0] addr_log [$];
    exp_t        exp_q [$];

    arm_fetch_unit #(
        .RESET_VECTOR (32'h0000_0000),
        .DEPTH        (2)
    ) dut (
        .CLK         (CLK),
        .reset_n     (reset_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .flush       (flush),
        .flush_addr  (flush_addr),
        .flush_thumb (flush_thumb),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_thumb (instr_thumb),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0] + 16'h1357};
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] pc, input logic thumb);
        exp_t        e;
        logic [31:0] w;
        w       = mem_word({pc[31:2], 2'b00});
        e.pc    = pc;
        e.thumb = thumb;
        if (!thumb)     e.instr = w;
        else if (pc[1]) e.instr = {16'h0000, w[31:16]};
        else            e.instr = {16'h0000, w[15:0]};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic hold_reset();
        @(negedge CLK);
        reset_n     = 1'b0;
        ack_budget  = 0;
        flush       = 1'b0;
        instr_ready = 1'b0;
        step(2);
        exp_q.delete();
    endtask

    task automatic release_reset();
        @(negedge CLK);
        addr_log.delete();
        reset_n = 1'b1;
    endtask

    // Memory responder: acks after ack_delay waiting cycles while budget lasts.
    always @(negedge CLK) begin
        if (!reset_n || !mem_req) begin
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            wait_cnt  = 0;
            pend      = 1'b0;
        end else begin
            if (pend) chk("addr_stable", mem_addr, pend_addr);
            if (!pend) begin
                pend      = 1'b1;
                pend_addr = mem_addr;
            end
            if (ack_budget > 0 && wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                addr_log.push_back(mem_addr);
                ack_budget--;
                wait_cnt  = 0;
                pend      = 1'b0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
                if (ack_budget > 0) wait_cnt++;
                else                wait_cnt = 0;
            end
        end
    end

    // Scoreboard: every accepted head must match the next expected entry.
    always begin
        exp_t e;
        @(negedge CLK);
        #2;
        if (reset_n && instr_valid && instr_ready && !flush) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", {31'b0, instr_valid}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", instr_pc, e.pc);
                chk("pop_instr", instr, e.instr);
                chk("pop_thumb", {31'b0, instr_thumb}, {31'b0, e.thumb});
            end
        end
    end

    initial begin
        reset_n     = 1'b0;
        flush       = 1'b0;
        flush_addr  = 32'h0;
        flush_thumb = 1'b0;
        instr_ready = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'h0;
        step(2);
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_instr_thumb", {31'b0, instr_thumb}, 32'h0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);

        // Streaming: ack every cycle, decode always ready.
        instr_ready = 1'b1; ack_delay = 0; ack_budget = 3;
        exp_q.push_back(mk_exp(32'h0, 1'b0));
        exp_q.push_back(mk_exp(32'h4, 1'b0));
        exp_q.push_back(mk_exp(32'h8, 1'b0));
        release_reset();
        step(1);
        chk("t1_first_req", {31'b0, mem_req}, 32'h1);
        chk("t1_first_addr", mem_addr, 32'h0);
        step(1);
        chk("t1_valid", {31'b0, instr_valid}, 32'h1);
        chk("t1_pc0", instr_pc, 32'h0);
        step(1);
        chk("t1_pc4", instr_pc, 32'h4);
        step(1);
        chk("t1_pc8", instr_pc, 32'h8);
        step(3);
        chk("t1_sb_empty", exp_q.size(), 32'd0);
        chk("t1_nacks", addr_log.size(), 32'd3);
        chk("t1_addr2", addr_log[2], 32'h8);

        // Back-pressure: two acks fill the queue, one pop lets one more in.
        hold_reset();
        ack_delay = 0; ack_budget = 10;
        release_reset();
        step(3);
        chk("t2_full_noreq", {31'b0, mem_req}, 32'h0);
        chk("t2_full_valid", {31'b0, instr_valid}, 32'h1);
        step(3);
        chk("t2_still_noreq", {31'b0, mem_req}, 32'h0);
        chk("t2_nacks_full", addr_log.size(), 32'd2);
        exp_q.push_back(mk_exp(32'h0, 1'b0));
        instr_ready = 1'b1;
        step(1);
        instr_ready = 1'b0;
        step(6);
        chk("t2_nacks_after_pop", addr_log.size(), 32'd3);
        chk("t2_refill_addr", addr_log[addr_log.size()-1], 32'h8);
        chk("t2_idle_again", {31'b0, mem_req}, 32'h0);
        chk("t2_head", instr_pc, 32'h4);
        chk("t2_sb_empty", exp_q.size(), 32'd0);

        // Flush to Thumb while a slow request at 0x10 is outstanding.
        hold_reset();
        instr_ready = 1'b1; ack_delay = 0; ack_budget = 4;
        for (int i = 0; i < 4; i++) exp_q.push_back(mk_exp(32'(i * 4), 1'b0));
        release_reset();
        step(8);
        chk("t3_pre_sb", exp_q.size(), 32'd0);
        chk("t3_pend_req", {31'b0, mem_req}, 32'h1);
        chk("t3_pend_addr", mem_addr, 32'h10);
        addr_log.delete();
        ack_delay = 3; ack_budget = 4;
        step(1);
        flush = 1'b1; flush_addr = 32'h101; flush_thumb = 1'b1;
        exp_q.push_back(mk_exp(32'h100, 1'b1));
        exp_q.push_back(mk_exp(32'h102, 1'b1));
        exp_q.push_back(mk_exp(32'h104, 1'b1));
        step(1);
        flush = 1'b0;
        chk("t3_flush_valid", {31'b0, instr_valid}, 32'h0);
        chk("t3_hold_req", {31'b0, mem_req}, 32'h1);
        chk("t3_hold_addr", mem_addr, 32'h10);
        step(25);
        chk("t3_sb_empty", exp_q.size(), 32'd0);
        chk("t3_nacks", addr_log.size(), 32'd4);
        chk("t3_a0", addr_log[0], 32'h10);
        chk("t3_a1", addr_log[1], 32'h100);
        chk("t3_a2", addr_log[2], 32'h100);
        chk("t3_a3", addr_log[3], 32'h104);

        // Flush coincident with the first ack: acked word dropped.
        hold_reset();
        instr_ready = 1'b1; ack_delay = 0; ack_budget = 1;
        release_reset();
        step(1);
        flush = 1'b1; flush_addr = 32'h200; flush_thumb = 1'b0;
        step(1);
        flush = 1'b0;
        chk("t4_valid", {31'b0, instr_valid}, 32'h0);
        chk("t4_req", {31'b0, mem_req}, 32'h1);
        chk("t4_addr", mem_addr, 32'h200);
        exp_q.push_back(mk_exp(32'h200, 1'b0));
        ack_budget = 1;
        step(6);
        chk("t4_sb_empty", exp_q.size(), 32'd0);
        chk("t4_nacks", addr_log.size(), 32'd2);

        // Flush plus pop with a full queue.
        hold_reset();
        ack_delay = 0; ack_budget = 2;
        release_reset();
        step(4);
        chk("t5_full_noreq", {31'b0, mem_req}, 32'h0);
        chk("t5_full_valid", {31'b0, instr_valid}, 32'h1);
        instr_ready = 1'b1; flush = 1'b1; flush_addr = 32'h300; flush_thumb = 1'b0;
        step(1);
        flush = 1'b0; instr_ready = 1'b0;
        chk("t5_valid", {31'b0, instr_valid}, 32'h0);
        chk("t5_req", {31'b0, mem_req}, 32'h1);
        chk("t5_addr", mem_addr, 32'h300);
        exp_q.push_back(mk_exp(32'h300, 1'b0));
        instr_ready = 1'b1; ack_budget = 1;
        step(6);
        chk("t5_sb_empty", exp_q.size(), 32'd0);

        // Asynchronous reset with a request outstanding.
        hold_reset();
        instr_ready = 1'b1; ack_delay = 0; ack_budget = 2;
        exp_q.push_back(mk_exp(32'h0, 1'b0));
        exp_q.push_back(mk_exp(32'h4, 1'b0));
        release_reset();
        step(5);
        chk("t6_pend_req", {31'b0, mem_req}, 32'h1);
        chk("t6_pend_addr", mem_addr, 32'h8);
        chk("t6_sb_empty", exp_q.size(), 32'd0);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6_async_req", {31'b0, mem_req}, 32'h0);
        chk("t6_async_addr", mem_addr, 32'h0);
        chk("t6_async_instr", instr, 32'h0);
        chk("t6_async_pc", instr_pc, 32'h0);
        chk("t6_async_thumb", {31'b0, instr_thumb}, 32'h0);
        chk("t6_async_valid", {31'b0, instr_valid}, 32'h0);
        ack_budget = 1;
        exp_q.push_back(mk_exp(32'h0, 1'b0));
        release_reset();
        step(1);
        chk("t6_restart_req", {31'b0, mem_req}, 32'h1);
        chk("t6_restart_addr", mem_addr, 32'h0);
        step(5);
        chk("t6_restart_sb", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
